cart_mem_arbiter: RTL and testbench
===================================

# cart_mem_arbiter

Two-channel memory access sequencer sitting directly downstream of the mapper blocks (MMC3-class mappers, including the Tengen variant). It captures CPU-side (PRG) and PPU-side (CHR) accesses already translated by the mapper, together with their allow qualifiers, and serialises them onto one external cartridge-memory port with a req/ack handshake. It then returns read data and completion pulses to each requester.

## Interface
Parameters:
- AW, 22, mapper output address width (matches prg_aout/chr_aout)
- DW, 8, data width

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- prg_req  in  1  one-cycle pulse: PRG access request
- prg_we  in  1  PRG write (1) / read (0), sampled with prg_req
- prg_addr  in  AW  mapper prg_aout, sampled with prg_req
- prg_wdata  in  DW  PRG write data, sampled with prg_req
- prg_allow  in  1  mapper prg_allow, sampled with prg_req
- prg_rdata  out  DW  PRG read result, held until next PRG completion
- prg_done  out  1  one-cycle PRG completion pulse
- chr_req, chr_we, chr_addr, chr_wdata, chr_allow  in  1/1/AW/DW/1  CHR equivalents
- chr_rdata  out  DW  CHR read result
- chr_done  out  1  one-cycle CHR completion pulse
- mem_req  out  1  external access request, held until mem_ack
- mem_we  out  1  external write strobe qualifier
- mem_addr  out  AW  external address
- mem_wdata  out  DW  external write data
- mem_ack  in  1  external completion; mem_rdata valid in the same cycle
- mem_rdata  in  DW  external read data
- overrun  out  1  sticky: request arrived on a channel already busy

## Operation
- Per channel, a pending latch captures {we, addr, wdata, allow} on req when the channel is idle (not pending and not in flight).
- req on a busy channel is ignored. overrun is set and stays set until reset.
- Disallowed access (allow=0) never reaches memory:
  - done pulses the cycle after capture.
  - A read returns OPEN_BUS (8'hFF).
  - A write is discarded.
- Arbiter states:
  - IDLE: no transaction.
  - ISSUE: mem_req=1, outputs driven from the granted channel; remains until mem_ack.
- Transitions:
  - IDLE→ISSUE when any allowed access is pending.
  - ISSUE→ISSUE on mem_ack if the other channel is pending (back-to-back; mem_req stays high, address/data switch).
  - ISSUE→IDLE on mem_ack otherwise.
- Grant: round-robin by last_grant when both channels are pending; a single pending channel is granted immediately. last_grant resets to PRG, so the first contended grant goes to CHR.
- On mem_ack, for the granted channel:
  - Reads latch mem_rdata into rdata.
  - done pulses the next cycle.
  - The pending latch clears in the ack cycle, so a new req is accepted from the ack cycle onward.
- mem_addr, mem_we and mem_wdata stay stable for the whole time mem_req is high.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, pending cleared, last_grant=PRG.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - prg_done=chr_done=0, prg_rdata=chr_rdata=OPEN_BUS, overrun=0.
- req sampled at edge of cycle 0 → mem_req high in cycle 1. If mem_ack arrives in cycle 1, done is high in cycle 2. The minimum latency is 2 cycles.
- Simultaneous prg_req and chr_req in the same cycle: both are captured, CHR is granted first (reset last_grant=PRG), and PRG follows back-to-back.
- A req arriving in the same cycle as that channel's mem_ack is accepted.
- Reset asserted mid-transaction aborts it: mem_req drops immediately and no done is issued.
- A write to memory still produces done; rdata is unchanged.

## Configuration
- CART_MEM_CHR_WRITE_EN defined: CHR writes with chr_allow=1 go to memory (CHR-RAM carts).
- Undefined: every CHR write is treated as disallowed (discarded, done next cycle, no memory cycle), regardless of chr_allow. CHR reads are unaffected.

## Structure
- Package cart_mem_pkg:
  - arb_state_t {IDLE, ISSUE}
  - chan_t {CH_PRG, CH_CHR}
  - OPEN_BUS = 8'hFF
  - default AW/DW constants
- Sub-module cart_mem_chan: pending latch, busy/overrun detection, disallowed short-circuit, rdata/done registers. Instantiated once per channel.
- The top level holds the arbiter FSM and the mux onto mem_*.

## Test plan
- Single PRG read of 0x1FFFF, allow=1, mem_ack one cycle after mem_req with rdata 0x5A → mem_addr=0x1FFFF, prg_done in cycle 2 after ack, prg_rdata=0x5A.
- Simultaneous chr_req (read 0x20400) and prg_req (write 0x0_8000 data 0x33) → CHR issued first, then PRG back-to-back with mem_req continuously high, mem_we=1 with mem_wdata=0x33 on the second transaction, both done pulses seen.
- prg_req with prg_allow=0 (read) → no mem_req, prg_done the next cycle, prg_rdata=0xFF.
- Second chr_req while the first is stalled (mem_ack held low 5 cycles) → second ignored, overrun=1 and sticky, exactly one chr_done.
- CHR write with chr_allow=1: macro defined → mem_we=1 cycle occurs; macro undefined → no mem_req, chr_done the next cycle.
- reset_n pulsed low while in ISSUE → mem_req=0 immediately, no done, all outputs at their reset values.

Source files
------------

// File: rtl/cart_mem_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
package cart_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef enum logic {
        CH_PRG = 1'b0,
        CH_CHR = 1'b1
    } chan_t;

    // Value returned for reads that never reach memory.
    localparam logic [7:0] OPEN_BUS = 8'hFF;

    localparam int AW_DEF = 22;
    localparam int DW_DEF = 8;

    // The channel that is not c; drives round-robin and back-to-back hand-over.
    function automatic chan_t other_chan(input chan_t c);
        return (c == CH_PRG) ? CH_CHR : CH_PRG;
    endfunction

endpackage

// File: rtl/cart_mem_chan.sv
// One requester channel: pending latch, overrun detection, short-circuit
// completion of disallowed accesses, and the rdata/done return registers.
module cart_mem_chan
    import cart_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    input  logic          allow,
    input  logic          ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          pend_nxt,
    output logic          p_we,
    output logic [AW-1:0] p_addr,
    output logic [DW-1:0] p_wdata,
    output logic [DW-1:0] rdata,
    output logic          done,
    output logic          overrun
);

    logic pend;
    logic idle;
    logic accept;
    logic take;

    // The ack cycle already frees the channel, so a request coinciding with
    // its own ack is accepted rather than flagged as an overrun.
    assign idle     = !pend || ack;
    assign accept   = req && idle;
    assign take     = accept && allow;
    assign pend_nxt = take ? 1'b1 : (ack ? 1'b0 : pend);

    // Pending latch, completion pulse, read-data return and sticky overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= 1'b0;
            p_we    <= 1'b0;
            p_addr  <= '0;
            p_wdata <= '0;
            rdata   <= DW'(OPEN_BUS);
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (take) begin
                p_we    <= we;
                p_addr  <= addr;
                p_wdata <= wdata;
            end
            done <= ack || (accept && !allow);
            if (accept && !allow && !we)
                rdata <= DW'(OPEN_BUS);
            else if (ack && !p_we)
                rdata <= mem_rdata;
            if (req && !idle)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/cart_mem_arbiter.sv
// Two-channel (PRG/CHR) sequencer serialising mapper-translated accesses onto
// one req/ack cartridge memory port with round-robin arbitration.
// Build option: CART_MEM_CHR_WRITE_EN lets allowed CHR writes reach memory
// (CHR-RAM carts); without it every CHR write completes locally.
module cart_mem_arbiter
    import cart_mem_pkg::*;
#(
    parameter int AW = 22,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          prg_req,
    input  logic          prg_we,
    input  logic [AW-1:0] prg_addr,
    input  logic [DW-1:0] prg_wdata,
    input  logic          prg_allow,
    output logic [DW-1:0] prg_rdata,
    output logic          prg_done,
    input  logic          chr_req,
    input  logic          chr_we,
    input  logic [AW-1:0] chr_addr,
    input  logic [DW-1:0] chr_wdata,
    input  logic          chr_allow,
    output logic [DW-1:0] chr_rdata,
    output logic          chr_done,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          overrun
);

    arb_state_t    state, state_nxt;
    chan_t         grant, grant_nxt;
    logic          chr_allow_eff;
    logic          prg_ack, chr_ack;
    logic          prg_pn, chr_pn;
    logic          prg_p_we, chr_p_we;
    logic [AW-1:0] prg_p_addr, chr_p_addr;
    logic [DW-1:0] prg_p_wdata, chr_p_wdata;
    logic          prg_ovr, chr_ovr;
    logic          other_pn;

`ifdef CART_MEM_CHR_WRITE_EN
    assign chr_allow_eff = chr_allow;
`else
    assign chr_allow_eff = chr_allow && !chr_we;
`endif

    assign prg_ack = mem_ack && (state == ISSUE) && (grant == CH_PRG);
    assign chr_ack = mem_ack && (state == ISSUE) && (grant == CH_CHR);
    assign overrun = prg_ovr || chr_ovr;

    cart_mem_chan #(.AW(AW), .DW(DW)) u_prg (
        .clk(clk), .reset_n(reset_n),
        .req(prg_req), .we(prg_we), .addr(prg_addr), .wdata(prg_wdata),
        .allow(prg_allow), .ack(prg_ack), .mem_rdata(mem_rdata),
        .pend_nxt(prg_pn), .p_we(prg_p_we), .p_addr(prg_p_addr),
        .p_wdata(prg_p_wdata), .rdata(prg_rdata), .done(prg_done),
        .overrun(prg_ovr)
    );

    cart_mem_chan #(.AW(AW), .DW(DW)) u_chr (
        .clk(clk), .reset_n(reset_n),
        .req(chr_req), .we(chr_we), .addr(chr_addr), .wdata(chr_wdata),
        .allow(chr_allow_eff), .ack(chr_ack), .mem_rdata(mem_rdata),
        .pend_nxt(chr_pn), .p_we(chr_p_we), .p_addr(chr_p_addr),
        .p_wdata(chr_p_wdata), .rdata(chr_rdata), .done(chr_done),
        .overrun(chr_ovr)
    );

    // State and grant registers; grant doubles as last_grant while idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= CH_PRG;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
        end
    end

    // Next state looks at next-cycle pending so a request captured at this
    // edge is already on the memory port in the following cycle.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        other_pn  = (grant == CH_PRG) ? chr_pn : prg_pn;
        case (state)
            IDLE: begin
                if (prg_pn && chr_pn) begin
                    state_nxt = ISSUE;
                    grant_nxt = other_chan(grant);
                end else if (prg_pn) begin
                    state_nxt = ISSUE;
                    grant_nxt = CH_PRG;
                end else if (chr_pn) begin
                    state_nxt = ISSUE;
                    grant_nxt = CH_CHR;
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    if (other_pn)
                        grant_nxt = other_chan(grant);
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port driven from the granted channel's latched request.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (state == ISSUE) begin
            mem_req = 1'b1;
            if (grant == CH_PRG) begin
                mem_we    = prg_p_we;
                mem_addr  = prg_p_addr;
                mem_wdata = prg_p_wdata;
            end else begin
                mem_we    = chr_p_we;
                mem_addr  = chr_p_addr;
                mem_wdata = chr_p_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: directed steps followed by a
// randomized phase scored against a memory-level reference model.
module tb_cart_mem_arbiter;

    localparam int AW = 22;
    localparam int DW = 8;
`ifdef CART_MEM_CHR_WRITE_EN
    localparam bit CHR_WR = 1'b1;
`else
    localparam bit CHR_WR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          prg_req, prg_we, prg_allow;
    logic [AW-1:0] prg_addr;
    logic [DW-1:0] prg_wdata, prg_rdata;
    logic          prg_done;
    logic          chr_req, chr_we, chr_allow;
    logic [AW-1:0] chr_addr;
    logic [DW-1:0] chr_wdata, chr_rdata;
    logic          chr_done;
    logic          mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          overrun;

    logic          auto_ack;
    logic          m_ack, a_ack;
    logic [DW-1:0] m_rdata, a_rdata;

    assign mem_ack   = auto_ack ? a_ack : m_ack;
    assign mem_rdata = auto_ack ? a_rdata : m_rdata;

    always #5 clk = ~clk;

    cart_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr),
        .prg_wdata(prg_wdata), .prg_allow(prg_allow),
        .prg_rdata(prg_rdata), .prg_done(prg_done),
        .chr_req(chr_req), .chr_we(chr_we), .chr_addr(chr_addr),
        .chr_wdata(chr_wdata), .chr_allow(chr_allow),
        .chr_rdata(chr_rdata), .chr_done(chr_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .overrun(overrun)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // External memory device used during the randomized phase.
    logic [DW-1:0] ext_mem [32];
    logic [DW-1:0] ref_mem [32];
    int            ack_cnt = 0;
    int            stab_err = 0;
    bit            r_busy = 1'b0;
    int            r_dly = 0;
    logic [AW-1:0] h_addr;
    logic          h_we;
    logic [DW-1:0] h_wdata;

    function automatic int idx(input logic [AW-1:0] a);
        return int'({a[AW-1], a[3:0]});
    endfunction

    always @(posedge clk) begin
        #2;
        if (auto_ack) begin
            a_ack = 1'b0;
            if (mem_req) begin
                if (!r_busy) begin
                    r_busy  = 1'b1;
                    r_dly   = int'($urandom_range(0, 3));
                    h_addr  = mem_addr;
                    h_we    = mem_we;
                    h_wdata = mem_wdata;
                end else if (mem_addr !== h_addr || mem_we !== h_we || mem_wdata !== h_wdata) begin
                    stab_err++;
                end
                if (r_dly == 0) begin
                    a_ack = 1'b1;
                    if (mem_we) ext_mem[idx(mem_addr)] = mem_wdata;
                    else        a_rdata = ext_mem[idx(mem_addr)];
                    ack_cnt++;
                    r_busy = 1'b0;
                end else begin
                    r_dly--;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bit found;
        bit do_p, do_c, p_ok, c_ok;
        int need_p, need_c, pd, cd, exp_cyc;
        logic [DW-1:0] exp_prg, exp_chr;

        reset_n = 1'b0; auto_ack = 1'b0;
        m_ack = 1'b0; m_rdata = '0; a_ack = 1'b0; a_rdata = '0;
        prg_req = 0; prg_we = 0; prg_addr = '0; prg_wdata = '0; prg_allow = 0;
        chr_req = 0; chr_we = 0; chr_addr = '0; chr_wdata = '0; chr_allow = 0;
        for (int i = 0; i < 32; i++) begin
            ext_mem[i] = 8'(i * 37);
            ref_mem[i] = 8'(i * 37);
        end

        // Reset state
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_prg_rdata", 32'(prg_rdata), 32'hFF);
        chk("rst_chr_rdata", 32'(chr_rdata), 32'hFF);
        chk("rst_dones", 32'({prg_done, chr_done}), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset_n = 1'b1;
        tick();

        // Single PRG read
        prg_req = 1; prg_we = 0; prg_addr = 22'h1FFFF; prg_allow = 1;
        tick();
        prg_req = 0;
        chk("t1_mem_req", 32'(mem_req), 1);
        chk("t1_mem_addr", 32'(mem_addr), 32'h1FFFF);
        chk("t1_mem_we", 32'(mem_we), 0);
        chk("t1_done_early", 32'(prg_done), 0);
        m_ack = 1; m_rdata = 8'h5A;
        tick();
        m_ack = 0;
        chk("t1_prg_done", 32'(prg_done), 1);
        chk("t1_prg_rdata", 32'(prg_rdata), 32'h5A);
        chk("t1_mem_req_off", 32'(mem_req), 0);
        tick();
        chk("t1_done_pulse", 32'(prg_done), 0);

        // Simultaneous CHR read and PRG write
        chr_req = 1; chr_we = 0; chr_addr = 22'h20400; chr_allow = 1;
        prg_req = 1; prg_we = 1; prg_addr = 22'h08000; prg_wdata = 8'h33; prg_allow = 1;
        tick();
        chr_req = 0; prg_req = 0;
        chk("t2_req1", 32'(mem_req), 1);
        chk("t2_addr1", 32'(mem_addr), 32'h20400);
        chk("t2_we1", 32'(mem_we), 0);
        m_ack = 1; m_rdata = 8'hC3;
        tick();
        chk("t2_req2", 32'(mem_req), 1);
        chk("t2_addr2", 32'(mem_addr), 32'h08000);
        chk("t2_we2", 32'(mem_we), 1);
        chk("t2_wdata2", 32'(mem_wdata), 32'h33);
        chk("t2_chr_done", 32'(chr_done), 1);
        chk("t2_chr_rdata", 32'(chr_rdata), 32'hC3);
        chk("t2_prg_done_early", 32'(prg_done), 0);
        m_rdata = 8'hEE;
        tick();
        m_ack = 0;
        chk("t2_req_off", 32'(mem_req), 0);
        chk("t2_prg_done", 32'(prg_done), 1);
        chk("t2_prg_rdata_kept", 32'(prg_rdata), 32'h5A);
        chk("t2_chr_done_pulse", 32'(chr_done), 0);
        tick();

        // Disallowed PRG read
        prg_req = 1; prg_we = 0; prg_addr = 22'h00ABC; prg_allow = 0;
        tick();
        prg_req = 0;
        chk("t3_no_mem_req", 32'(mem_req), 0);
        chk("t3_prg_done", 32'(prg_done), 1);
        chk("t3_prg_rdata", 32'(prg_rdata), 32'hFF);
        tick();
        chk("t3_done_pulse", 32'(prg_done), 0);
        chk("t3_no_mem_req2", 32'(mem_req), 0);

        // Overrun on a stalled CHR channel
        cnt = 0;
        chr_req = 1; chr_we = 0; chr_addr = 22'h00123; chr_allow = 1;
        tick(); cnt += int'(chr_done);
        chk("t4_mem_req", 32'(mem_req), 1);
        chr_addr = 22'h00456;
        tick(); cnt += int'(chr_done);
        chr_req = 0;
        chk("t4_overrun", 32'(overrun), 1);
        chk("t4_addr_held", 32'(mem_addr), 32'h00123);
        for (int i = 0; i < 4; i++) begin
            tick(); cnt += int'(chr_done);
        end
        chk("t4_still_req", 32'(mem_req), 1);
        m_ack = 1; m_rdata = 8'h77;
        tick(); cnt += int'(chr_done);
        m_ack = 0;
        chk("t4_chr_done", 32'(chr_done), 1);
        chk("t4_chr_rdata", 32'(chr_rdata), 32'h77);
        for (int i = 0; i < 5; i++) begin
            tick(); cnt += int'(chr_done);
        end
        chk("t4_done_count", 32'(cnt), 1);
        chk("t4_no_second_txn", 32'(mem_req), 0);
        chk("t4_overrun_sticky", 32'(overrun), 1);

        // CHR write with chr_allow=1
        chr_req = 1; chr_we = 1; chr_addr = 22'h00321; chr_wdata = 8'h9C; chr_allow = 1;
        tick();
        chr_req = 0;
`ifdef CART_MEM_CHR_WRITE_EN
        chk("t5_mem_req", 32'(mem_req), 1);
        chk("t5_mem_we", 32'(mem_we), 1);
        chk("t5_mem_wdata", 32'(mem_wdata), 32'h9C);
        chk("t5_done_early", 32'(chr_done), 0);
        m_ack = 1;
        tick();
        m_ack = 0;
        chk("t5_chr_done", 32'(chr_done), 1);
        chk("t5_chr_rdata", 32'(chr_rdata), 32'h77);
        chk("t5_req_off", 32'(mem_req), 0);
`else
        chk("t5_no_mem_req", 32'(mem_req), 0);
        chk("t5_chr_done", 32'(chr_done), 1);
        chk("t5_chr_rdata", 32'(chr_rdata), 32'h77);
        tick();
        chk("t5_done_pulse", 32'(chr_done), 0);
        chk("t5_no_mem_req2", 32'(mem_req), 0);
`endif
        tick();

        // Reset in the middle of a transaction
        prg_req = 1; prg_we = 0; prg_addr = 22'h03333; prg_allow = 1;
        tick();
        prg_req = 0;
        chk("t6_mem_req", 32'(mem_req), 1);
        #3; reset_n = 1'b0; #1;
        chk("t6_req_drop", 32'(mem_req), 0);
        chk("t6_addr_zero", 32'(mem_addr), 0);
        chk("t6_overrun_clr", 32'(overrun), 0);
        chk("t6_rdata", 32'({prg_rdata, chr_rdata}), 32'hFFFF);
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); cnt += int'(prg_done) + int'(mem_req);
        end
        chk("t6_no_done_no_req", 32'(cnt), 0);

        // New request in the same cycle as its own ack
        prg_req = 1; prg_we = 0; prg_addr = 22'h00100; prg_allow = 1;
        tick();
        chk("t7_mem_req", 32'(mem_req), 1);
        m_ack = 1; m_rdata = 8'h11;
        prg_addr = 22'h00200;
        tick();
        m_ack = 0; prg_req = 0;
        chk("t7_done1", 32'(prg_done), 1);
        chk("t7_rdata1", 32'(prg_rdata), 32'h11);
        found = 0;
        for (int i = 0; i < 5; i++) begin
            if (!found && mem_req) found = 1;
            if (!found) tick();
        end
        chk("t7_second_issued", 32'(found), 1);
        chk("t7_addr2", 32'(mem_addr), 32'h00200);
        m_ack = 1; m_rdata = 8'h22;
        tick();
        m_ack = 0;
        chk("t7_done2", 32'(prg_done), 1);
        chk("t7_rdata2", 32'(prg_rdata), 32'h22);
        chk("t7_no_overrun", 32'(overrun), 0);
        tick(); tick();

        // Randomized phase against the memory-level model
        auto_ack = 1'b1;
        exp_cyc = 0;
        exp_prg = prg_rdata;
        exp_chr = chr_rdata;
        for (int it = 0; it < 60; it++) begin
            do_p = ($urandom_range(0, 3) != 0);
            do_c = ($urandom_range(0, 3) != 0);
            prg_we = 1'($urandom); prg_allow = ($urandom_range(0, 3) != 0);
            prg_addr = {1'b0, 21'($urandom)}; prg_wdata = 8'($urandom);
            chr_we = 1'($urandom); chr_allow = ($urandom_range(0, 3) != 0);
            chr_addr = {1'b1, 21'($urandom)}; chr_wdata = 8'($urandom);
            p_ok = prg_allow;
            c_ok = chr_allow && (!chr_we || CHR_WR);
            need_p = int'(do_p);
            need_c = int'(do_c);
            if (do_p) begin
                if (p_ok) exp_cyc++;
                if (p_ok && prg_we) ref_mem[idx(prg_addr)] = prg_wdata;
                else if (!prg_we) exp_prg = p_ok ? ref_mem[idx(prg_addr)] : 8'hFF;
            end
            if (do_c) begin
                if (c_ok) exp_cyc++;
                if (c_ok && chr_we) ref_mem[idx(chr_addr)] = chr_wdata;
                else if (!chr_we) exp_chr = c_ok ? ref_mem[idx(chr_addr)] : 8'hFF;
            end
            prg_req = do_p; chr_req = do_c;
            tick();
            prg_req = 0; chr_req = 0;
            pd = 0; cd = 0;
            for (int k = 0; k < 40; k++) begin
                pd += int'(prg_done);
                cd += int'(chr_done);
                if (pd >= need_p && cd >= need_c) break;
                tick();
            end
            chk("rnd_prg_done", 32'(pd), 32'(need_p));
            chk("rnd_chr_done", 32'(cd), 32'(need_c));
            chk("rnd_prg_rdata", 32'(prg_rdata), 32'(exp_prg));
            chk("rnd_chr_rdata", 32'(chr_rdata), 32'(exp_chr));
            tick();
        end
        tick(); tick();
        chk("rnd_mem_cycles", 32'(ack_cnt), 32'(exp_cyc));
        chk("rnd_stability", 32'(stab_err), 0);
        chk("rnd_no_overrun", 32'(overrun), 0);
        for (int i = 0; i < 32; i++)
            chk("rnd_mem_image", 32'(ext_mem[i]), 32'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
